// File: rtl/commit_pkg.sv
// commit_pkg: cause codes, privilege modes and FSM states shared by the commit stage
package commit_pkg;
  localparam logic [31:0] CAUSE_IMISALIGN = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_BREAK = 32'd3;
  localparam logic [31:0] CAUSE_LMISALIGN = 32'd4;
  localparam logic [31:0] CAUSE_SMISALIGN = 32'd6;
  localparam logic [31:0] CAUSE_ECALL_U = 32'd8;
  localparam logic [31:0] CAUSE_ECALL_S = 32'd9;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_M = 2'b11;
  typedef enum logic [1:0] {RUN, WAIT_MEM, TRAP, FLUSH} state_e;
endpackage

// File: rtl/commit_stage_trap_priority.sv
// trap_priority: folds interrupt, fault and xRET flags into one prioritised event
module trap_priority
  import commit_pkg::*;
(
  input  logic        irq_i,
  input  logic [3:0]  irq_code_i,
  input  logic        imis_i,
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        lmis_i,
  input  logic        smis_i,
  input  logic        mret_i,
  input  logic        sret_i,
  input  logic        uret_i,
  input  logic [1:0]  mode_i,
  input  logic        tsr_i,
  output logic        ev_o,
  output logic        is_trap_o,
  output logic [1:0]  ret_kind_o,
  output logic [31:0] cause_o
);
  logic ill_ret;
  logic [31:0] ecall_cause;
  always_comb begin
    ill_ret = (mret_i && mode_i != MODE_M) ||
              (sret_i && (mode_i == MODE_U || (tsr_i && mode_i == MODE_S)));
    ecall_cause = mode_i == MODE_M ? CAUSE_ECALL_M : mode_i == MODE_S ? CAUSE_ECALL_S : CAUSE_ECALL_U;
    cause_o = irq_i ? {1'b1, 27'b0, irq_code_i} :
              imis_i ? CAUSE_IMISALIGN :
              (illegal_i || ill_ret) ? CAUSE_ILLEGAL :
              ebreak_i ? CAUSE_BREAK :
              ecall_i ? ecall_cause :
              lmis_i ? CAUSE_LMISALIGN :
              smis_i ? CAUSE_SMISALIGN : 32'd0;
    is_trap_o = irq_i || imis_i || illegal_i || ill_ret || ebreak_i || ecall_i || lmis_i || smis_i;
    ev_o = is_trap_o || mret_i || sret_i || uret_i;
    // ret_kind reuses the privilege encoding of the returning mode
    ret_kind_o = mret_i ? MODE_M : sret_i ? MODE_S : MODE_U;
  end
endmodule

// File: rtl/commit_stage.sv
// commit_stage: registers stage-5 write-back and sequences traps/xRETs with a fixed flush window
module commit_stage
  import commit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid5,
  input  logic        we5,
  input  logic [4:0]  rd5,
  input  logic [31:0] result5,
  input  logic        csr_we5,
  input  logic [11:0] csr_addr5,
  input  logic [31:0] csr_wdata5,
  input  logic [31:0] pc5,
  input  logic        instruction_addr_misaligned5,
  input  logic        illegal_instr5,
  input  logic        ecall5,
  input  logic        ebreak5,
  input  logic        load_misaligned5,
  input  logic        store_misaligned5,
  input  logic        mret5,
  input  logic        sret5,
  input  logic        uret5,
  input  logic        irq_pending,
  input  logic [3:0]  irq_code,
  input  logic [1:0]  current_mode,
  input  logic        TSR,
  input  logic        mem_busy,
  output logic        we6,
  output logic [4:0]  rdaddr6,
  output logic [31:0] wb6,
  output logic        csr_we6,
  output logic [11:0] csr_wb_addr,
  output logic [31:0] csr_wb,
  output logic        exception_pending,
  output logic [31:0] cause,
  output logic [31:0] pc_exc,
  output logic        m_ret,
  output logic        s_ret,
  output logic        u_ret,
  output logic        exception
);
  logic ev, is_trap, fire, f_trap;
  logic [1:0] ret_kind, f_kind;
  logic [31:0] t_cause, f_cause, f_pc;
  state_e state_q;
  logic [1:0] cnt_q, kind_q;
  logic trap_q, we_q, csr_we_q, pend_q, mret_q, sret_q, uret_q, exc_q;
  logic [4:0] rd_q;
  logic [11:0] csr_addr_q;
  logic [31:0] wb_q, csr_wb_q, cause_q, pc_q, cause_l_q, pc_l_q;
  trap_priority u_tp (
    .irq_i(irq_pending), .irq_code_i(irq_code), .imis_i(instruction_addr_misaligned5),
    .illegal_i(illegal_instr5), .ecall_i(ecall5), .ebreak_i(ebreak5),
    .lmis_i(load_misaligned5), .smis_i(store_misaligned5),
    .mret_i(mret5), .sret_i(sret5), .uret_i(uret5), .mode_i(current_mode), .tsr_i(TSR),
    .ev_o(ev), .is_trap_o(is_trap), .ret_kind_o(ret_kind), .cause_o(t_cause)
  );
  // a trap fires straight from RUN, or from WAIT_MEM once memory goes idle using the latched event
  always_comb begin
    fire = !mem_busy && ((state_q == RUN && valid5 && ev) || state_q == WAIT_MEM);
    f_trap = state_q == WAIT_MEM ? trap_q : is_trap;
    f_kind = state_q == WAIT_MEM ? kind_q : ret_kind;
    f_cause = state_q == WAIT_MEM ? cause_l_q : t_cause;
    f_pc = state_q == WAIT_MEM ? pc_l_q : pc5;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RUN;
      {cnt_q, kind_q, trap_q, we_q, csr_we_q, pend_q, mret_q, sret_q, uret_q, exc_q} <= '0;
      {rd_q, csr_addr_q, wb_q, csr_wb_q, cause_q, pc_q, cause_l_q, pc_l_q} <= '0;
    end else begin
      {we_q, csr_we_q, pend_q, mret_q, sret_q, uret_q} <= '0;
      if (fire) begin
        state_q <= TRAP;
        cnt_q <= 2'(FLUSH_CYCLES - 1);
        exc_q <= 1'b1;
        pend_q <= f_trap;
        mret_q <= !f_trap && f_kind == MODE_M;
        sret_q <= !f_trap && f_kind == MODE_S;
        uret_q <= !f_trap && f_kind == MODE_U;
        if (f_trap) begin
          cause_q <= f_cause;
          pc_q <= f_pc;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (valid5 && ev) begin
              state_q <= WAIT_MEM;
              exc_q <= 1'b1;
              trap_q <= is_trap;
              kind_q <= ret_kind;
              cause_l_q <= t_cause;
              pc_l_q <= pc5;
            end else if (valid5) begin
              we_q <= we5 && rd5 != 5'd0;
              rd_q <= rd5;
              wb_q <= result5;
              csr_we_q <= csr_we5;
              csr_addr_q <= csr_addr5;
              csr_wb_q <= csr_wdata5;
            end
          end
          WAIT_MEM: state_q <= WAIT_MEM;
          TRAP, FLUSH: begin
            if (cnt_q == 2'd0) begin
              state_q <= RUN;
              exc_q <= 1'b0;
            end else begin
              state_q <= FLUSH;
              cnt_q <= cnt_q - 2'd1;
            end
          end
        endcase
      end
    end
  end
  assign we6 = we_q;
  assign rdaddr6 = rd_q;
  assign wb6 = wb_q;
  assign csr_we6 = csr_we_q;
  assign csr_wb_addr = csr_addr_q;
  assign csr_wb = csr_wb_q;
  assign exception_pending = pend_q;
  assign cause = cause_q;
  assign pc_exc = pc_q;
  assign m_ret = mret_q;
  assign s_ret = sret_q;
  assign u_ret = uret_q;
  assign exception = exc_q;
endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: directed vectors for commit, trap priority, memory wait and reset
module tb_commit_stage;
  logic clk = 1'b0, nrst = 1'b0;
  logic valid5, we5, csr_we5, imis, illegal, ecall, ebreak, lmis, smis;
  logic mret5, sret5, uret5, irq_pending, TSR, mem_busy;
  logic [4:0] rd5;
  logic [31:0] result5, csr_wdata5, pc5;
  logic [11:0] csr_addr5;
  logic [3:0] irq_code;
  logic [1:0] current_mode;
  logic we6, csr_we6, exception_pending, m_ret, s_ret, u_ret, exception;
  logic [4:0] rdaddr6;
  logic [31:0] wb6, csr_wb, cause, pc_exc;
  logic [11:0] csr_wb_addr;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  commit_stage #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .nrst(nrst), .valid5(valid5), .we5(we5), .rd5(rd5), .result5(result5),
    .csr_we5(csr_we5), .csr_addr5(csr_addr5), .csr_wdata5(csr_wdata5), .pc5(pc5),
    .instruction_addr_misaligned5(imis), .illegal_instr5(illegal), .ecall5(ecall),
    .ebreak5(ebreak), .load_misaligned5(lmis), .store_misaligned5(smis),
    .mret5(mret5), .sret5(sret5), .uret5(uret5), .irq_pending(irq_pending),
    .irq_code(irq_code), .current_mode(current_mode), .TSR(TSR), .mem_busy(mem_busy),
    .we6(we6), .rdaddr6(rdaddr6), .wb6(wb6), .csr_we6(csr_we6), .csr_wb_addr(csr_wb_addr),
    .csr_wb(csr_wb), .exception_pending(exception_pending), .cause(cause), .pc_exc(pc_exc),
    .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret), .exception(exception)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {valid5, we5, csr_we5, imis, illegal, ecall, ebreak, lmis, smis} = '0;
    {mret5, sret5, uret5, irq_pending, TSR, mem_busy} = '0;
    rd5 = 5'd0; result5 = 32'd0; csr_addr5 = 12'd0; csr_wdata5 = 32'd0;
    pc5 = 32'd0; irq_code = 4'd0; current_mode = 2'b11;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    tick();
    chk("flush_hold", {31'd0, exception}, 32'd1);
    tick();
    chk("flush_end", {31'd0, exception}, 32'd0);
  endtask

  initial begin
    idle();
    #12;
    chk("rst_flags", {25'd0, we6, csr_we6, exception_pending, m_ret, s_ret, u_ret, exception}, 32'd0);
    chk("rst_cause", cause, 32'd0);
    chk("rst_pc_exc", pc_exc, 32'd0);
    chk("rst_wb6", wb6, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    // plain commit
    valid5 = 1'b1; we5 = 1'b1; rd5 = 5'd5; result5 = 32'hDEADBEEF;
    csr_we5 = 1'b1; csr_addr5 = 12'h300; csr_wdata5 = 32'h12345678;
    tick();
    chk("commit_we6", {31'd0, we6}, 32'd1);
    chk("commit_rd", {27'd0, rdaddr6}, 32'd5);
    chk("commit_wb", wb6, 32'hDEADBEEF);
    chk("commit_csr_we", {31'd0, csr_we6}, 32'd1);
    chk("commit_csr_addr", {20'd0, csr_wb_addr}, 32'h300);
    chk("commit_csr_wb", csr_wb, 32'h12345678);
    rd5 = 5'd0; csr_we5 = 1'b0;
    tick();
    chk("rd0_we6", {31'd0, we6}, 32'd0);
    chk("rd0_csr_we", {31'd0, csr_we6}, 32'd0);
    idle();
    tick();
    chk("idle_we6", {31'd0, we6}, 32'd0);
    // illegal instruction with write requests that must be suppressed
    valid5 = 1'b1; illegal = 1'b1; pc5 = 32'h100; we5 = 1'b1; rd5 = 5'd3; csr_we5 = 1'b1;
    tick();
    chk("ill_pend", {31'd0, exception_pending}, 32'd1);
    chk("ill_cause", cause, 32'd2);
    chk("ill_pc", pc_exc, 32'h100);
    chk("ill_exc", {31'd0, exception}, 32'd1);
    chk("ill_nowrite", {30'd0, we6, csr_we6}, 32'd0);
    idle();
    valid5 = 1'b1; we5 = 1'b1; rd5 = 5'd7; illegal = 1'b1;
    tick();
    chk("ill_pulse", {31'd0, exception_pending}, 32'd0);
    chk("ill_flush_exc", {31'd0, exception}, 32'd1);
    chk("ill_flush_nowrite", {31'd0, we6}, 32'd0);
    idle();
    tick();
    chk("ill_run_exc", {31'd0, exception}, 32'd0);
    chk("ill_cause_hold", cause, 32'd2);
    // ecall in S, alone and with a lower-priority load misalign
    valid5 = 1'b1; ecall = 1'b1; current_mode = 2'b01; pc5 = 32'h200;
    tick();
    chk("ecall_s_cause", cause, 32'd9);
    chk("ecall_s_pend", {31'd0, exception_pending}, 32'd1);
    drain();
    valid5 = 1'b1; ecall = 1'b1; lmis = 1'b1; current_mode = 2'b01; pc5 = 32'h204;
    tick();
    chk("ecall_lmis_cause", cause, 32'd9);
    drain();
    // legal mret in M
    valid5 = 1'b1; mret5 = 1'b1; current_mode = 2'b11; pc5 = 32'h208;
    tick();
    chk("mret_pulses", {28'd0, exception_pending, m_ret, s_ret, u_ret}, 32'b0100);
    chk("mret_exc", {31'd0, exception}, 32'd1);
    chk("mret_pc_hold", pc_exc, 32'h204);
    drain();
    chk("mret_pulse_end", {31'd0, m_ret}, 32'd0);
    // sret trapped by TSR in S mode
    valid5 = 1'b1; sret5 = 1'b1; TSR = 1'b1; current_mode = 2'b01; pc5 = 32'h20C;
    tick();
    chk("sret_tsr_cause", cause, 32'd2);
    chk("sret_tsr_flags", {30'd0, exception_pending, s_ret}, 32'b10);
    drain();
    // ebreak waiting on memory for three edges
    valid5 = 1'b1; ebreak = 1'b1; mem_busy = 1'b1; pc5 = 32'h300;
    tick();
    chk("wait0", {30'd0, exception_pending, exception}, 32'b01);
    idle(); mem_busy = 1'b1;
    tick();
    chk("wait1", {30'd0, exception_pending, exception}, 32'b01);
    tick();
    chk("wait2", {30'd0, exception_pending, exception}, 32'b01);
    chk("wait_cause_hold", cause, 32'd2);
    mem_busy = 1'b0;
    tick();
    chk("wait_pend", {31'd0, exception_pending}, 32'd1);
    chk("wait_cause", cause, 32'd3);
    chk("wait_pc", pc_exc, 32'h300);
    drain();
    // interrupt ignored without a live instruction
    irq_pending = 1'b1; irq_code = 4'd7;
    tick();
    chk("irq_novalid", {30'd0, exception_pending, exception}, 32'd0);
    // interrupt beats illegal instruction, then reset during the flush
    valid5 = 1'b1; illegal = 1'b1; we5 = 1'b1; rd5 = 5'd9; pc5 = 32'h400;
    tick();
    chk("irq_cause", cause, 32'h80000007);
    chk("irq_pc", pc_exc, 32'h400);
    chk("irq_flags", {30'd0, exception_pending, we6}, 32'b10);
    idle();
    tick();
    chk("irq_flush", {31'd0, exception}, 32'd1);
    nrst = 1'b0;
    #2;
    chk("arst_flags", {25'd0, we6, csr_we6, exception_pending, m_ret, s_ret, u_ret, exception}, 32'd0);
    chk("arst_cause", cause, 32'd0);
    chk("arst_pc", pc_exc, 32'd0);
    #2;
    nrst = 1'b1;
    tick();
    chk("post_rst", {30'd0, exception_pending, exception}, 32'd0);
    valid5 = 1'b1; we5 = 1'b1; rd5 = 5'd10; result5 = 32'hCAFEF00D;
    tick();
    chk("post_rst_we6", {31'd0, we6}, 32'd1);
    chk("post_rst_wb", wb6, 32'hCAFEF00D);
    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
